peak_search_ctrl: RTL and testbench
===================================

Name: peak_search_ctrl

Overview:
Frame-level controller that sequences the peak-magnitude search over complex I/Q samples. It accepts a stream of N samples per frame with a valid/ready handshake and computes |I|²+|Q|² per sample. It tracks the frame maximum and its in-frame index, then presents one result per frame on a valid/ready output. It replaces free-running, never-cleared peak tracking with explicit start/abort/report sequencing, so downstream logic gets one clean peak per frame.

Parameters:
N, 128, samples per frame (>=2)
IW, 32, signed width of data_i / data_q
IDXW, 8, index width; must satisfy 2**IDXW >= N
MW, 65, magnitude width (2*IW+1)

Ports:
clk  in  1  clock, all logic on rising edge
rstn  in  1  asynchronous active-low reset
start  in  1  single-cycle pulse: arm a new frame (honoured in IDLE only)
abort  in  1  single-cycle pulse: drop current frame/result, return to IDLE
in_valid  in  1  sample valid
in_ready  out  1  block can accept a sample
data_i  in  IW  signed in-phase sample
data_q  in  IW  signed quadrature sample
res_valid  out  1  frame result valid
res_ready  in  1  downstream accepts result
res_mag  out  MW  unsigned peak magnitude of the frame
res_index  out  IDXW  in-frame index (0..N-1) of the peak
busy  out  1  high in ACCUM or REPORT

Behaviour:
- Reset (rstn low, async): state=IDLE, in_ready=0, res_valid=0, res_mag=0, res_index=0, busy=0, sample counter=0, running max=0.
- Magnitude: mag = data_i*data_i + data_q*data_q, signed products, zero-extended into MW bits, treated as unsigned. The worst case (-2^(IW-1), -2^(IW-1)) gives 2^(2IW-1) with no overflow.
- States:
  - IDLE: in_ready=0.
    - start=1 and abort=0 -> ACCUM. Counter and running max/index are cleared.
  - ACCUM: in_ready=1.
    - Accepting a sample (in_valid & in_ready) increments the counter.
    - Sample 0 always loads max/index unconditionally.
    - Later samples update only if mag > running max (strict). Ties keep the earliest index.
    - Acceptance of sample N-1 -> REPORT. The final comparison is included in the result.
  - REPORT: in_ready=0 (back-pressure upstream).
    - res_valid=1; res_mag and res_index are stable until the handshake.
    - res_valid & res_ready -> IDLE. The optional feature changes this exit.
- Latency: last sample accepted at edge t -> res_valid high after edge t, i.e. visible from cycle t+1.
- res_mag/res_index are registered and change only when REPORT is entered. They hold their value in IDLE until the next report.
- abort: from any state -> IDLE at the next edge; res_valid deasserts; counter is cleared.
  - abort has priority over start, a sample acceptance, and a result handshake in the same cycle.
  - An aborted result is not counted as delivered.
- start pulses in ACCUM/REPORT are ignored (no queueing).
- in_valid while in_ready=0 is ignored. Data is not captured, and upstream must hold it.
- Counter wraps only through the explicit clear; it never exceeds N-1.

Optional Feature:
Macro PEAK_SEARCH_AUTO_RESTART_EN.
- Defined: a result handshake in REPORT goes directly to ACCUM, with counter and running max cleared, so consecutive frames run without start pulses.
  - The first frame still requires start.
  - abort still returns to IDLE and stops auto-restart.
- Undefined: a result handshake returns to IDLE, and each frame needs a start pulse.

Test Plan:
- Reset then idle: hold in_valid=1 without start -> in_ready=0, res_valid stays 0, outputs stay 0.
- Single peak: start; N=128 samples with I=Q=k for sample k, except sample 37 at I=1000,Q=-1000 -> res_mag=2,000,000, res_index=37, res_valid one cycle after sample 127 is accepted.
- Ties and extremes:
  - All samples (3,4) -> res_mag=25, res_index=0.
  - Sample 90 at I=Q=-2^31 -> res_mag=2^63, res_index=90.
- Backpressure both sides:
  - Random in_valid gaps -> result unchanged vs gap-free run.
  - res_ready low 20 cycles -> res_valid, res_mag, res_index held, in_ready=0 throughout.
- Abort: abort after 50 samples, same cycle as a sample -> IDLE, sample dropped. A new start plus 128 fresh samples reports only the new frame's peak; abort concurrent with res_ready -> no handshake counted.
- With PEAK_SEARCH_AUTO_RESTART_EN: one start, three frames back-to-back with peaks at indices 5, 127, 0 -> three results in order. in_ready returns high the cycle after each handshake; without the macro, the FSM is in IDLE after the first result.

Source files
------------

// File: rtl/peak_search_ctrl.sv
// peak_search_ctrl: frame-sequenced peak |I|^2+|Q|^2 search with one registered result per frame.
// Optional PEAK_SEARCH_AUTO_RESTART_EN: a result handshake re-arms the next frame without start.
module peak_search_ctrl #(
  parameter int N    = 128,
  parameter int IW   = 32,
  parameter int IDXW = 8,
  parameter int MW   = 65
) (
  input  logic                 clk,
  input  logic                 rstn,
  input  logic                 start,
  input  logic                 abort,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic signed [IW-1:0] data_i,
  input  logic signed [IW-1:0] data_q,
  output logic                 res_valid,
  input  logic                 res_ready,
  output logic [MW-1:0]        res_mag,
  output logic [IDXW-1:0]      res_index,
  output logic                 busy
);
  typedef enum logic [1:0] {IDLE, ACCUM, REPORT} state_t;
  localparam logic [IDXW-1:0] LAST = IDXW'(N - 1);
`ifdef PEAK_SEARCH_AUTO_RESTART_EN
  localparam logic AUTO = 1'b1;
`else
  localparam logic AUTO = 1'b0;
`endif
  state_t                 r_state, w_next;
  logic [IDXW-1:0]        r_cnt, r_idx, r_res_idx;
  logic [MW-1:0]          r_max, r_res_mag, w_mag;
  logic signed [2*IW-1:0] w_sqi, w_sqq;
  logic                   w_acc, w_last, w_hs, w_clr, w_take;
  // Squares are non-negative, so the unsigned view of each product is exact.
  assign w_sqi  = (2*IW)'(data_i) * (2*IW)'(data_i);
  assign w_sqq  = (2*IW)'(data_q) * (2*IW)'(data_q);
  assign w_mag  = MW'($unsigned(w_sqi)) + MW'($unsigned(w_sqq));
  assign w_acc  = (r_state == ACCUM) && in_valid;
  assign w_last = w_acc && (r_cnt == LAST);
  assign w_hs   = (r_state == REPORT) && res_ready;
  assign w_clr  = ((r_state == IDLE) && start) || (w_hs && AUTO);
  assign w_take = (r_cnt == '0) || (w_mag > r_max);
  always_ff @(posedge clk or negedge rstn)
    if (!rstn) r_state <= IDLE;
    else       r_state <= w_next;
  always_comb begin
    w_next = r_state;
    if (abort)                               w_next = IDLE;
    else if ((r_state == IDLE) && start)     w_next = ACCUM;
    else if (w_last)                         w_next = REPORT;
    else if (w_hs)                           w_next = AUTO ? ACCUM : IDLE;
  end
  // abort outranks every other update; the reported result survives it.
  always_ff @(posedge clk or negedge rstn)
    if (!rstn) begin
      r_cnt     <= '0;
      r_max     <= '0;
      r_idx     <= '0;
      r_res_mag <= '0;
      r_res_idx <= '0;
    end else if (abort) begin
      r_cnt <= '0;
    end else if (w_clr) begin
      r_cnt <= '0;
      r_max <= '0;
      r_idx <= '0;
    end else if (w_acc) begin
      r_cnt <= w_last ? '0 : r_cnt + IDXW'(1);
      if (w_take) begin
        r_max <= w_mag;
        r_idx <= r_cnt;
      end
      if (w_last) begin
        r_res_mag <= w_take ? w_mag : r_max;
        r_res_idx <= w_take ? r_cnt : r_idx;
      end
    end
  assign in_ready  = (r_state == ACCUM);
  assign res_valid = (r_state == REPORT);
  assign busy      = (r_state != IDLE);
  assign res_mag   = r_res_mag;
  assign res_index = r_res_idx;
endmodule

// File: tb/tb_peak_search_ctrl.sv
// tb_peak_search_ctrl: table-driven frame vectors plus directed abort / back-pressure sequences.
module tb_peak_search_ctrl;
  localparam int N = 128;
  logic               clk = 0, rstn = 0, start = 0, abort = 0, in_valid = 0, res_ready = 0;
  logic signed [31:0] data_i = 0, data_q = 0;
  logic               in_ready, res_valid, busy;
  logic [64:0]        res_mag;
  logic [7:0]         res_index;
  int                 checks = 0, failures = 0, delivered = 0, exp_deliv = 0;
  logic [64:0]        last_mag = 0;

  peak_search_ctrl dut (
    .clk(clk), .rstn(rstn), .start(start), .abort(abort),
    .in_valid(in_valid), .in_ready(in_ready), .data_i(data_i), .data_q(data_q),
    .res_valid(res_valid), .res_ready(res_ready), .res_mag(res_mag),
    .res_index(res_index), .busy(busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) if (res_valid && res_ready && !abort) delivered++;

  typedef struct {
    int          kind;
    bit          gaps;
    int          hold;
    logic [64:0] mag;
    logic [7:0]  idx;
    bit          midstart;
  } vec_t;
  vec_t tbl[8];

  task automatic chk(input string n, input logic [64:0] act, input logic [64:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", n, act, exp);
    end
  endtask

  task automatic gen(input int kind, input int k, output logic signed [31:0] i, output logic signed [31:0] q);
    case (kind)
      0:       begin i = (k == 37) ? 1000 : k; q = (k == 37) ? -1000 : k; end
      1:       begin i = 3; q = 4; end
      2:       begin i = (k == 90) ? 32'sh8000_0000 : k; q = i; end
      3:       begin i = k; q = k; end
      4:       begin i = 127 - k; q = 127 - k; end
      5:       begin i = (k == 5) ? 500 : 1; q = (k == 5) ? 0 : 1; end
      default: begin i = (k < 10) ? k : 9; q = 0; end
    endcase
  endtask

  task automatic send(input logic signed [31:0] i, input logic signed [31:0] q, input bit st);
    int w = 0;
    data_i = i; data_q = q; in_valid = 1; start = st;
    while (!in_ready && w < 50) begin @(negedge clk); w++; end
    if (w >= 50) chk("in_ready_timeout", 0, 1);
    @(posedge clk);
    @(negedge clk);
    in_valid = 0; start = 0;
  endtask

  task automatic run_frame(input vec_t v, input bit do_start, input bit abort_hs);
    logic signed [31:0] i, q;
    if (do_start) begin start = 1; @(negedge clk); start = 0; end
    for (int k = 0; k < N; k++) begin
      gen(v.kind, k, i, q);
      if (k == N - 1) chk("valid_before_last", res_valid, 0);
      send(i, q, v.midstart && k == 60);
      if (v.gaps && k < N - 1 && $urandom_range(0, 2) == 0) repeat ($urandom_range(1, 3)) @(negedge clk);
    end
    chk("latency_valid", res_valid, 1);
    chk("report_in_ready", in_ready, 0);
    chk("res_mag", res_mag, v.mag);
    chk("res_index", res_index, v.idx);
    in_valid = 1;
    for (int h = 0; h < v.hold; h++) begin
      @(negedge clk);
      chk("hold_valid", res_valid, 1);
      chk("hold_mag", res_mag, v.mag);
      chk("hold_index", res_index, v.idx);
      chk("hold_in_ready", in_ready, 0);
    end
    in_valid = 0;
    res_ready = 1; abort = abort_hs;
    @(posedge clk);
    @(negedge clk);
    res_ready = 0; abort = 0;
    chk("post_hs_valid", res_valid, 0);
    chk("post_hs_mag_kept", res_mag, v.mag);
    if (abort_hs) begin
      chk("abort_hs_in_ready", in_ready, 0);
      chk("abort_hs_busy", busy, 0);
    end else begin
      exp_deliv++;
`ifdef PEAK_SEARCH_AUTO_RESTART_EN
      chk("restart_in_ready", in_ready, 1);
`else
      chk("idle_in_ready", in_ready, 0);
      chk("idle_busy", busy, 0);
`endif
    end
    last_mag = v.mag;
  endtask

  initial begin
    #3_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    logic signed [31:0] i, q;
    tbl[0] = '{0, 0, 0, 65'd2000000, 8'd37, 0};
    tbl[1] = '{1, 0, 0, 65'd25, 8'd0, 0};
    tbl[2] = '{2, 0, 0, 65'h8000_0000_0000_0000, 8'd90, 0};
    tbl[3] = '{0, 1, 0, 65'd2000000, 8'd37, 1};
    tbl[4] = '{3, 0, 20, 65'd32258, 8'd127, 0};
    tbl[5] = '{4, 1, 3, 65'd32258, 8'd0, 0};
    tbl[6] = '{6, 0, 0, 65'd81, 8'd9, 0};
    tbl[7] = '{5, 0, 1, 65'd250000, 8'd5, 0};
    repeat (3) @(negedge clk);
    chk("rst_in_ready", in_ready, 0);
    chk("rst_res_valid", res_valid, 0);
    rstn = 1;
    in_valid = 1; data_i = 7; data_q = 7;
    repeat (4) begin
      @(negedge clk);
      chk("idle_in_ready", in_ready, 0);
      chk("idle_res_valid", res_valid, 0);
      chk("idle_busy", busy, 0);
      chk("idle_mag", res_mag, 0);
      chk("idle_index", res_index, 0);
    end
    in_valid = 0;
    for (int r = 0; r < 8; r++) run_frame(tbl[r], 1, 0);
    start = 1; @(negedge clk); start = 0;
    for (int k = 0; k < 50; k++) begin gen(0, k, i, q); send(i, q, 0); end
    data_i = 30000; data_q = 30000; in_valid = 1; abort = 1;
    @(posedge clk);
    @(negedge clk);
    abort = 0;
    chk("abort_in_ready", in_ready, 0);
    chk("abort_busy", busy, 0);
    chk("abort_res_valid", res_valid, 0);
    chk("abort_mag_kept", res_mag, last_mag);
    repeat (3) @(negedge clk);
    chk("abort_stays_idle", in_ready, 0);
    in_valid = 0;
    run_frame('{3, 0, 0, 65'd32258, 8'd127, 0}, 1, 0);
    run_frame('{1, 0, 2, 65'd25, 8'd0, 0}, 1, 1);
`ifdef PEAK_SEARCH_AUTO_RESTART_EN
    run_frame('{5, 0, 0, 65'd250000, 8'd5, 0}, 1, 0);
    run_frame('{3, 1, 0, 65'd32258, 8'd127, 0}, 0, 0);
    run_frame('{4, 0, 0, 65'd32258, 8'd0, 0}, 0, 0);
    abort = 1; @(negedge clk); abort = 0;
    chk("final_abort_idle", in_ready, 0);
`endif
    repeat (2) @(negedge clk);
    chk("deliveries", delivered, exp_deliv);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
